// File: rtl/mac_tx_scheduler_if.sv
// rtl/mac_tx_scheduler_if.sv - request/frame-generator bundle for mac_tx_scheduler
//
// Purpose: carries the requester-side and frame-generator-side signals of the
// transmit scheduler so they travel as one port.
// Ports (as seen by the scheduler, modport slave):
//   i_enable      in   1         permits new grants
//   i_req         in   N_REQ     level request per requester
//   i_len         in   N_REQ*16  packed payload lengths, requester k at [16k+15:16k]
//   i_gen_done    in   1         frame-generator completion pulse
//   o_gen_start   out  1         one-cycle start pulse to the frame generator
//   o_gen_len     out  16        clamped payload length of the granted requester
//   o_grant       out  N_REQ     one-hot grant
//   o_ack         out  N_REQ     one-cycle completion pulse to the granted requester
//   o_timeout     out  1         one-cycle pulse when the generator never finished
//   o_busy        out  1         high whenever the scheduler is not idle
//   o_frame_count out  32        completed frames, wraps at 2^32
interface mac_tx_scheduler_if #(
  parameter int N_REQ = 4
);
  logic                  i_enable;
  logic [N_REQ-1:0]      i_req;
  logic [N_REQ*16-1:0]   i_len;
  logic                  i_gen_done;
  logic                  o_gen_start;
  logic [15:0]           o_gen_len;
  logic [N_REQ-1:0]      o_grant;
  logic [N_REQ-1:0]      o_ack;
  logic                  o_timeout;
  logic                  o_busy;
  logic [31:0]           o_frame_count;

  modport master (
    output i_enable, i_req, i_len, i_gen_done,
    input  o_gen_start, o_gen_len, o_grant, o_ack, o_timeout, o_busy, o_frame_count
  );

  modport slave (
    input  i_enable, i_req, i_len, i_gen_done,
    output o_gen_start, o_gen_len, o_grant, o_ack, o_timeout, o_busy, o_frame_count
  );
endinterface

// File: rtl/mac_tx_scheduler.sv
// rtl/mac_tx_scheduler.sv - round-robin transmit scheduler driving a frame generator
//
// Purpose: picks one requester at a time (round-robin), hands its clamped
// payload length to the frame generator, waits for completion or timeout,
// then enforces an inter-packet gap before the next grant.
// Ports:
//   clk      in  1  clock
//   i_rst_n  in  1  asynchronous active-low reset
//   bus      mac_tx_scheduler_if.slave  requester and generator signals
// Parameters:
//   N_REQ          number of requesters
//   IPG_CYCLES     idle gap between frames in clocks (>= 1)
//   TIMEOUT_CYCLES maximum wait for generator done
module mac_tx_scheduler #(
  parameter int N_REQ          = 4,
  parameter int IPG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  mac_tx_scheduler_if.slave       bus
);

  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IPG_W  = $clog2(IPG_CYCLES + 1);
  localparam logic [15:0] MIN_LEN = 16'd46;
  localparam logic [15:0] MAX_LEN = 16'd1500;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_IPG
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;   // first index searched at the next grant
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [IPG_W-1:0]    ipg_q, ipg_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [15:0]         len_q, len_d;
  logic                start_q, start_d;
  logic                timeout_q, timeout_d;
  logic                busy_q, busy_d;
  logic [31:0]         count_q, count_d;

  logic                found;
  logic [N_REQ-1:0]    win_onehot;
  logic [15:0]         win_len;
  logic [IDX_W-1:0]    win_next;

  function automatic logic [15:0] clamp_len(input logic [15:0] len);
    if (len < MIN_LEN) return MIN_LEN;
    else if (len > MAX_LEN) return MAX_LEN;
    else return len;
  endfunction

  // Round-robin search as two ordered passes: indices from the pointer up to
  // the top, then the wrapped-around indices below the pointer.
  always_comb begin
    found      = 1'b0;
    win_onehot = '0;
    win_len    = '0;
    win_next   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && (j >= int'(rr_ptr_q)) && bus.i_req[j]) begin
        found         = 1'b1;
        win_onehot[j] = 1'b1;
        win_len       = bus.i_len[j*16 +: 16];
        win_next      = (j == N_REQ - 1) ? '0 : IDX_W'(j + 1);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && (j < int'(rr_ptr_q)) && bus.i_req[j]) begin
        found         = 1'b1;
        win_onehot[j] = 1'b1;
        win_len       = bus.i_len[j*16 +: 16];
        win_next      = (j == N_REQ - 1) ? '0 : IDX_W'(j + 1);
      end
    end
  end

  // Next-state and next-output logic; every output is the registered copy.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    wait_d    = wait_q;
    ipg_d     = ipg_q;
    grant_d   = grant_q;
    len_d     = len_q;
    count_d   = count_q;
    start_d   = 1'b0;
    ack_d     = '0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_enable && found) begin
          state_d  = S_START;
          grant_d  = win_onehot;
          len_d    = clamp_len(win_len);
          start_d  = 1'b1;
          rr_ptr_d = win_next;
        end
      end
      S_START: begin
        state_d = S_WAIT_DONE;
        wait_d  = '0;
      end
      S_WAIT_DONE: begin
        // Done is tested first so that it wins over a coincident expiry.
        if (bus.i_gen_done) begin
          state_d = S_IPG;
          ack_d   = grant_q;
          count_d = count_q + 32'd1;
          grant_d = '0;
          ipg_d   = '0;
        end else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_IPG;
          timeout_d = 1'b1;
          grant_d   = '0;
          ipg_d     = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_IPG: begin
        if (ipg_q == IPG_W'(IPG_CYCLES - 1)) state_d = S_IDLE;
        else ipg_d = ipg_q + IPG_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      wait_q    <= '0;
      ipg_q     <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      len_q     <= '0;
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      wait_q    <= wait_d;
      ipg_q     <= ipg_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      len_q     <= len_d;
      start_q   <= start_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
    end
  end

  assign bus.o_gen_start   = start_q;
  assign bus.o_gen_len     = len_q;
  assign bus.o_grant       = grant_q;
  assign bus.o_ack         = ack_q;
  assign bus.o_timeout     = timeout_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_frame_count = count_q;

endmodule

// File: tb/tb_mac_tx_scheduler.sv
// tb/tb_mac_tx_scheduler.sv - self-checking bench for mac_tx_scheduler
module tb_mac_tx_scheduler;

  localparam int N   = 4;
  localparam int IPG = 12;
  localparam int TMO = 1024;

  logic clk;
  logic i_rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  // Reference model state: last granted index (-1 = none since reset) and frame count.
  int          model_last = -1;
  logic [31:0] model_count = 0;

  typedef struct {
    bit          ok;
    logic [3:0]  g;
    logic [15:0] l;
    int          t_start;
    int          t_end;
    logic [3:0]  ack;
    logic        tmo;
    bit          hold_ok;
    bit          pulse_ok;
    logic [31:0] cnt;
    logic [15:0] l_end;
    logic [3:0]  g_end;
  } obs_t;

  mac_tx_scheduler_if #(.N_REQ(N)) bus ();

  mac_tx_scheduler #(
    .N_REQ(N),
    .IPG_CYCLES(IPG),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .i_rst_n(i_rst_n),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int exp_winner(input logic [3:0] r);
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (model_last + 1 + i) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [15:0] clamp(input logic [15:0] v);
    if (v < 16'd46) return 16'd46;
    if (v > 16'd1500) return 16'd1500;
    return v;
  endfunction

  task automatic do_reset();
    bus.i_enable = 0; bus.i_req = '0; bus.i_len = '0; bus.i_gen_done = 0;
    i_rst_n = 0;
    repeat (3) @(negedge clk);
    i_rst_n = 1;
    model_last = -1;
    model_count = 0;
    @(negedge clk);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < IPG + TMO + 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.o_busy === 1'b0) ok = 1;
    end
  endtask

  // Observes one frame. d>0: raise done on the d-th cycle of WAIT_DONE; d<0: never.
  // mode 1: scramble i_len/i_req after grant; mode 2: drop i_enable after grant.
  task automatic run_frame(input int d, input int mode, output obs_t o);
    bit started;
    bit ended;
    int k;
    started = 0; ended = 0; k = 0;
    o = '{default: 0};
    o.hold_ok = 1; o.pulse_ok = 1;
    for (int i = 0; i < 60 && !started; i++) begin
      @(negedge clk);
      if (bus.o_gen_start === 1'b1) started = 1;
    end
    if (!started) return;
    o.g = bus.o_grant; o.l = bus.o_gen_len; o.t_start = cyc;
    if (mode == 1) begin
      bus.i_len = {$urandom(), $urandom()};
      bus.i_req = 4'($urandom());
    end
    if (mode == 2) bus.i_enable = 0;
    while (!ended && k < TMO + 20) begin
      @(negedge clk);
      k++;
      bus.i_gen_done = (k == d);
      if (bus.o_gen_start !== 1'b0) o.pulse_ok = 0;
      if (bus.o_ack !== '0 || bus.o_timeout !== 1'b0) ended = 1;
      else if (bus.o_grant !== o.g) o.hold_ok = 0;
    end
    bus.i_gen_done = 0;
    if (!ended) return;
    o.t_end = cyc; o.ack = bus.o_ack; o.tmo = bus.o_timeout; o.cnt = bus.o_frame_count;
    o.l_end = bus.o_gen_len; o.g_end = bus.o_grant;
    @(negedge clk);
    if (bus.o_ack !== '0 || bus.o_timeout !== 1'b0) o.pulse_ok = 0;
    o.ok = 1;
  endtask

  task automatic test_reset();
    logic [88:0] outs;
    i_rst_n = 0; bus.i_enable = 1; bus.i_req = 4'hF; bus.i_len = '1; bus.i_gen_done = 1;
    repeat (3) @(negedge clk);
    outs = {bus.o_gen_start, bus.o_gen_len, bus.o_grant, bus.o_ack, bus.o_timeout, bus.o_busy, bus.o_frame_count, 32'd0};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", outs); end
    bus.i_enable = 0; bus.i_gen_done = 0;
    i_rst_n = 1; model_last = -1; model_count = 0;
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.o_busy, bus.o_gen_start, bus.o_grant} !== 6'd0) begin
      errors++; $display("FAIL reset_disabled_idle: got %b want 0", {bus.o_busy, bus.o_gen_start, bus.o_grant});
    end
  endtask

  task automatic test_single();
    obs_t o;
    int w;
    bit ok;
    do_reset();
    bus.i_req = 4'b0001; bus.i_len = {48'h0, 16'd100}; bus.i_enable = 1;
    w = exp_winner(4'b0001);
    run_frame(20, 1, o);
    checks++; if (!o.ok) begin errors++; $display("FAIL single_complete: got 0 want 1"); end
    checks++; if (o.g !== 4'(1 << w)) begin errors++; $display("FAIL single_grant: got %b want %b", o.g, 4'(1 << w)); end
    checks++; if (o.l !== clamp(16'd100)) begin errors++; $display("FAIL single_len: got %0d want 100", o.l); end
    checks++; if (o.t_end - o.t_start !== 21) begin errors++; $display("FAIL single_latency: got %0d want 21", o.t_end - o.t_start); end
    checks++; if (o.ack !== o.g || !o.pulse_ok) begin errors++; $display("FAIL single_ack: got %b pulse_ok %0d want %b", o.ack, o.pulse_ok, o.g); end
    checks++; if (o.l_end !== 16'd100 || !o.hold_ok) begin errors++; $display("FAIL single_hold: got len %0d hold %0d want 100 1", o.l_end, o.hold_ok); end
    model_last = w; model_count++;
    checks++; if (o.cnt !== model_count) begin errors++; $display("FAIL single_count: got %0d want %0d", o.cnt, model_count); end
    checks++; if (o.g_end !== 4'd0) begin errors++; $display("FAIL single_grant_ipg: got %b want 0", o.g_end); end
    bus.i_req = '0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_idle: got busy want idle"); end
  endtask

  task automatic test_round_robin();
    obs_t o;
    int w, prev;
    logic [15:0] el;
    bit ok;
    do_reset();
    bus.i_req = 4'hF; bus.i_len = {$urandom(), $urandom()}; bus.i_enable = 1;
    prev = 0;
    for (int f = 0; f < 5; f++) begin
      w = exp_winner(4'hF);
      el = clamp(bus.i_len[w*16 +: 16]);
      run_frame(1, 0, o);
      bus.i_len = {$urandom(), $urandom()};
      checks++; if (!o.ok || o.g !== 4'(1 << w)) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", f, o.g, 4'(1 << w)); end
      checks++; if (o.l !== el) begin errors++; $display("FAIL rr_len%0d: got %0d want %0d", f, o.l, el); end
      if (f > 0) begin
        checks++; if (o.t_start - prev !== 15) begin errors++; $display("FAIL rr_spacing%0d: got %0d want 15", f, o.t_start - prev); end
      end
      prev = o.t_start;
      model_last = w; model_count++;
      checks++; if (o.ack !== o.g || o.cnt !== model_count) begin errors++; $display("FAIL rr_ack%0d: got %b/%0d want %b/%0d", f, o.ack, o.cnt, o.g, model_count); end
    end
    bus.i_req = '0; bus.i_enable = 0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_idle: got busy want idle"); end
  endtask

  task automatic test_clamp();
    logic [15:0] vals [10];
    obs_t o;
    bit ok;
    vals = '{16'd10, 16'd9000, 16'd46, 16'd1500, 16'd45, 16'd47, 16'd1499, 16'd1501, 16'd0, 16'hFFFF};
    bus.i_req = 4'b0100; bus.i_enable = 1;
    for (int i = 0; i < 10; i++) begin
      bus.i_len = {$urandom(), $urandom()};
      bus.i_len[32 +: 16] = vals[i];
      run_frame(2, 0, o);
      checks++; if (!o.ok || o.l !== clamp(vals[i])) begin errors++; $display("FAIL clamp_%0d: got %0d want %0d", vals[i], o.l, clamp(vals[i])); end
      model_last = 2; model_count++;
    end
    bus.i_req = '0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL clamp_idle: got busy want idle"); end
  endtask

  task automatic test_timeout();
    obs_t o;
    int w;
    bit ok;
    bus.i_req = 4'b0010; bus.i_len = {$urandom(), $urandom()}; bus.i_enable = 1;
    w = exp_winner(4'b0010);
    run_frame(-1, 0, o);
    checks++; if (!o.ok || o.tmo !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b want 1", o.tmo); end
    checks++; if (o.t_end - o.t_start !== TMO + 1) begin errors++; $display("FAIL tmo_time: got %0d want %0d", o.t_end - o.t_start, TMO + 1); end
    checks++; if (o.ack !== 4'd0 || o.cnt !== model_count) begin errors++; $display("FAIL tmo_noack: got %b/%0d want 0/%0d", o.ack, o.cnt, model_count); end
    checks++; if (!o.pulse_ok || o.g_end !== 4'd0) begin errors++; $display("FAIL tmo_width: got pulse_ok %0d grant %b want 1 0", o.pulse_ok, o.g_end); end
    model_last = w;
    w = exp_winner(4'b0010);
    run_frame(TMO, 0, o);
    model_last = w; model_count++;
    checks++; if (!o.ok || o.g !== 4'(1 << w)) begin errors++; $display("FAIL tmo_next_grant: got %b want %b", o.g, 4'(1 << w)); end
    checks++; if (o.ack !== o.g || o.tmo !== 1'b0) begin errors++; $display("FAIL tmo_coincident: got ack %b tmo %b want %b 0", o.ack, o.tmo, o.g); end
    checks++; if (o.cnt !== model_count || o.t_end - o.t_start !== TMO + 1) begin errors++; $display("FAIL tmo_coincident_count: got %0d want %0d", o.cnt, model_count); end
    bus.i_req = '0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_idle: got busy want idle"); end
  endtask

  task automatic test_disable_reset();
    obs_t o;
    int w;
    bit regrant, started;
    logic [88:0] outs;
    do_reset();
    bus.i_req = 4'b0001; bus.i_len = {$urandom(), $urandom()}; bus.i_enable = 1;
    w = exp_winner(4'b0001);
    run_frame(3, 2, o);
    model_last = w; model_count++;
    checks++; if (!o.ok || o.ack !== 4'b0001 || o.cnt !== model_count) begin errors++; $display("FAIL dis_ack: got %b/%0d want 0001/%0d", o.ack, o.cnt, model_count); end
    regrant = 0;
    repeat (IPG + 20) begin
      @(negedge clk);
      if (bus.o_gen_start !== 1'b0 || bus.o_grant !== 4'd0) regrant = 1;
    end
    checks++; if (regrant || bus.o_busy !== 1'b0) begin errors++; $display("FAIL dis_no_regrant: got regrant %0d busy %b want 0 0", regrant, bus.o_busy); end
    bus.i_gen_done = 1;
    @(negedge clk);
    bus.i_gen_done = 0;
    @(negedge clk);
    checks++; if (bus.o_ack !== 4'd0 || bus.o_frame_count !== model_count) begin errors++; $display("FAIL stray_done: got %b/%0d want 0/%0d", bus.o_ack, bus.o_frame_count, model_count); end

    do_reset();
    bus.i_req = 4'b0110; bus.i_enable = 1;
    w = exp_winner(4'b0110);
    run_frame(1, 0, o);
    checks++; if (!o.ok || o.g !== 4'(1 << w)) begin errors++; $display("FAIL rst_first: got %b want %b", o.g, 4'(1 << w)); end
    model_last = w;
    started = 0;
    for (int i = 0; i < 60 && !started; i++) begin
      @(negedge clk);
      if (bus.o_gen_start === 1'b1) started = 1;
    end
    checks++; if (!started) begin errors++; $display("FAIL rst_second_start: got none want start"); end
    repeat (4) @(negedge clk);
    i_rst_n = 0;
    #1;
    outs = {bus.o_gen_start, bus.o_gen_len, bus.o_grant, bus.o_ack, bus.o_timeout, bus.o_busy, bus.o_frame_count, 32'd0};
    checks++; if (outs !== '0) begin errors++; $display("FAIL rst_mid_outputs: got %h want 0", outs); end
    repeat (2) @(negedge clk);
    i_rst_n = 1; model_last = -1; model_count = 0;
    w = exp_winner(4'b0110);
    run_frame(1, 0, o);
    model_last = w; model_count++;
    checks++; if (!o.ok || o.g !== 4'(1 << w) || o.ack !== o.g || o.cnt !== model_count) begin
      errors++; $display("FAIL rst_regrant: got %b/%b/%0d want %b/%b/%0d", o.g, o.ack, o.cnt, 4'(1 << w), 4'(1 << w), model_count);
    end
  endtask

  task automatic test_random();
    obs_t o;
    int w, d, prev_end;
    logic [3:0] r;
    logic [15:0] el;
    int bad_g, bad_l, bad_t, bad_a, bad_s;
    bad_g = 0; bad_l = 0; bad_t = 0; bad_a = 0; bad_s = 0;
    do_reset();
    prev_end = -1;
    for (int f = 0; f < 25; f++) begin
      r = 4'($urandom_range(1, 15));
      for (int s = 0; s < N; s++) begin
        case ($urandom_range(0, 2))
          0: bus.i_len[s*16 +: 16] = 16'($urandom_range(0, 45));
          1: bus.i_len[s*16 +: 16] = 16'($urandom_range(46, 1500));
          default: bus.i_len[s*16 +: 16] = 16'($urandom_range(1501, 65535));
        endcase
      end
      bus.i_req = r; bus.i_enable = 1;
      w = exp_winner(r);
      el = clamp(bus.i_len[w*16 +: 16]);
      d = $urandom_range(1, 30);
      run_frame(d, $urandom_range(0, 1), o);
      model_last = w; model_count++;
      if (!o.ok || o.g !== 4'(1 << w)) bad_g++;
      if (o.l !== el || o.l_end !== el) bad_l++;
      if (o.t_end - o.t_start !== d + 1) bad_t++;
      if (o.ack !== o.g || o.cnt !== model_count || !o.hold_ok || !o.pulse_ok) bad_a++;
      if (prev_end >= 0 && o.t_start - prev_end !== IPG + 1) bad_s++;
      prev_end = o.t_end;
    end
    checks++; if (bad_g != 0) begin errors++; $display("FAIL rand_grant: got %0d bad frames want 0", bad_g); end
    checks++; if (bad_l != 0) begin errors++; $display("FAIL rand_len: got %0d bad frames want 0", bad_l); end
    checks++; if (bad_t != 0) begin errors++; $display("FAIL rand_latency: got %0d bad frames want 0", bad_t); end
    checks++; if (bad_a != 0) begin errors++; $display("FAIL rand_ack: got %0d bad frames want 0", bad_a); end
    checks++; if (bad_s != 0) begin errors++; $display("FAIL rand_spacing: got %0d bad frames want 0", bad_s); end
  endtask

  initial begin
    i_rst_n = 0;
    bus.i_enable = 0; bus.i_req = '0; bus.i_len = '0; bus.i_gen_done = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_clamp();
    test_timeout();
    test_disable_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_tx_scheduler.md
MAC_TX_SCHEDULER -- requirements
Module: mac_tx_scheduler

Interface
REQ-001 Parameters SHALL be:
- N_REQ, default 4: number of requesters.
- IPG_CYCLES, default 12: idle gap between frames in clocks; must be >= 1.
- TIMEOUT_CYCLES, default 1024: maximum wait for generator done.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock.
- i_rst_n, in, 1: reset, asynchronous, active-low.
- i_enable, in, 1: permits new grants.
- i_req, in, N_REQ: level request per requester.
- i_len, in, N_REQ*16: packed payload length; requester k occupies bits [16k+15:16k].
- i_gen_done, in, 1: frame-generator completion pulse.
- o_gen_start, out, 1: one-cycle start pulse to the frame generator.
- o_gen_len, out, 16: clamped payload length of the granted requester.
- o_grant, out, N_REQ: one-hot grant.
- o_ack, out, N_REQ: one-cycle completion pulse to the granted requester.
- o_timeout, out, 1: one-cycle pulse when the generator failed to finish.
- o_busy, out, 1: high in any state except IDLE.
- o_frame_count, out, 32: count of completed frames.

Function
REQ-003 The FSM SHALL have states IDLE, START, WAIT_DONE and IPG; all outputs SHALL be registered.
REQ-004 IDLE: if i_enable=1 and |i_req=1 at edge t, the block SHALL enter START at t+1 with o_grant, o_gen_len and o_gen_start=1 valid in that cycle; otherwise it stays in IDLE.
REQ-005 Arbitration SHALL be round-robin: search starts at index (last_granted+1) mod N_REQ; after reset the search starts at index 0.
REQ-006 o_gen_len SHALL be i_len of the winner clamped: values <46 give 46, values >1500 give 1500, otherwise unchanged; it is latched at grant and held until the next grant.
REQ-007 START SHALL last exactly one cycle, then enter WAIT_DONE; o_gen_start SHALL be high only in START.
REQ-008 WAIT_DONE, normal completion: on i_gen_done=1 the block SHALL enter IPG, pulse o_ack bit of the granted index for one cycle, and increment o_frame_count (mod 2^32).
REQ-009 WAIT_DONE, timeout: a wait counter SHALL clear on entry; if TIMEOUT_CYCLES cycles elapse without i_gen_done, the block SHALL pulse o_timeout, enter IPG, give no o_ack and leave the count unchanged.
REQ-010 If i_gen_done and timeout expiry coincide, done SHALL win.
REQ-011 o_grant SHALL be one-hot, held from START through WAIT_DONE, and zero in IDLE and IPG.
REQ-012 IPG SHALL last exactly IPG_CYCLES cycles, then return to IDLE.
REQ-013 Earliest back-to-back start spacing SHALL be 1 (done) + IPG_CYCLES + 1 (IDLE) + 1 cycles.
REQ-014 i_gen_done outside WAIT_DONE SHALL be ignored.
REQ-015 Changes to i_req or i_len after grant SHALL be ignored for the current frame.
REQ-016 Deasserting i_enable mid-frame SHALL let the current frame and IPG complete; it only blocks the next grant.

Reset
REQ-017 While i_rst_n=0 the block SHALL hold state IDLE, round-robin pointer at index 0, all counters 0, and all outputs 0, including o_frame_count and o_gen_len.
REQ-018 Reset asserted mid-frame SHALL abort immediately, with no o_ack and no o_timeout; after release the first grant follows REQ-005 from index 0.

Verification
REQ-019 Scenario 1, single request: i_req=0001, i_len[0]=100, done 20 cycles after start -> o_gen_start one cycle, o_gen_len=100, o_grant=0001, o_ack=0001 one cycle, o_frame_count=1.
REQ-020 Scenario 2, round-robin: i_req=1111 held, done returned promptly -> grants 0001, 0010, 0100, 1000, 0001; each start exactly 15 cycles apart (IPG_CYCLES=12, done returned in the cycle after start).
REQ-021 Scenario 3, clamping: i_len=10 -> o_gen_len=46; i_len=9000 -> 1500; i_len=46 and 1500 -> unchanged.
REQ-022 Scenario 4, timeout: no done -> o_timeout pulse TIMEOUT_CYCLES cycles after WAIT_DONE entry, no o_ack, count unchanged, next grant proceeds; a coincident done still acks.
REQ-023 Scenario 5, disable and reset: i_enable drops during WAIT_DONE -> frame acks, then IDLE with no further grants; i_rst_n pulsed during WAIT_DONE -> all outputs 0 and the next grant goes to the lowest requesting index.
